// File: rtl/acc_alu_sequencer.sv
// Accumulator-side controller for an external combinational n-bit ALU.
// Sequences single-cycle ALU ops and an N-cycle unsigned shift-add multiply.
module acc_alu_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op_code,
  input  logic [N-1:0] op_data,
  output logic [N-1:0] acc,
  output logic [N-1:0] prod_hi,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_z,
  output logic         flag_n,
  output logic         done,
  output logic         err,
  output logic [N-1:0] alu_in0,
  output logic [N-1:0] alu_in1,
  output logic [2:0]   alu_ctrl,
  output logic         alu_c_in,
  input  logic [N-1:0] alu_result,
  input  logic         alu_c_out,
  input  logic         alu_v
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_CLR  = 4'd8;

  logic [1:0]    r_state;
  logic [3:0]    r_op;
  logic [N-1:0]  r_data;
  logic [N-1:0]  r_acc, r_prod_hi;
  logic          r_c, r_v, r_z, r_n;
  logic          r_done, r_err;
  logic [N-1:0]  r_p, r_l;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  w_in0, w_in1;
  logic [2:0]    w_ctrl;
  logic          w_cin;
  logic [N-1:0]  w_res;
  logic          w_c, w_v, w_ill;
  logic [N-1:0]  w_p_nx, w_l_nx;

  assign op_ready = (r_state == S_IDLE);
  assign acc      = r_acc;
  assign prod_hi  = r_prod_hi;
  assign flag_c   = r_c;
  assign flag_v   = r_v;
  assign flag_z   = r_z;
  assign flag_n   = r_n;
  assign done     = r_done;
  assign err      = r_err;
  assign alu_in0  = w_in0;
  assign alu_in1  = w_in1;
  assign alu_ctrl = w_ctrl;
  assign alu_c_in = w_cin;

  // During MUL the accumulator is the multiplicand; it is untouched until completion.
  always_comb begin
    w_in0  = r_acc;
    w_in1  = '0;
    w_ctrl = 3'b000;
    w_cin  = 1'b0;
    case (r_state)
      S_EXEC: begin
        w_in1 = r_data;
        case (r_op)
          OP_ADC:  w_cin = r_c;
          OP_SUB:  begin w_ctrl = 3'b001; w_cin = 1'b1; end
          OP_OR:   w_ctrl = 3'b010;
          OP_AND:  w_ctrl = 3'b100;
          OP_NOT:  w_ctrl = 3'b110;
          default: ;
        endcase
      end
      S_MUL: begin
        w_in0 = r_p;
        w_in1 = r_acc;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_res = r_acc;
    w_c   = r_c;
    w_v   = r_v;
    w_ill = 1'b0;
    case (r_op)
      OP_LOAD:                w_res = r_data;
      OP_ADD, OP_ADC, OP_SUB: begin w_res = alu_result; w_c = alu_c_out; w_v = alu_v; end
      OP_OR, OP_AND, OP_NOT:  begin w_res = alu_result; w_c = 1'b0; w_v = 1'b0; end
      OP_CLR:                 begin w_res = '0; w_c = 1'b0; w_v = 1'b0; end
      default:                w_ill = 1'b1;
    endcase
  end

  // One shift-add step: add M into P only when the multiplier LSB is set.
  always_comb begin
    if (r_l[0]) {w_p_nx, w_l_nx} = {alu_c_out, alu_result, r_l[N-1:1]};
    else        {w_p_nx, w_l_nx} = {1'b0, r_p, r_l[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_data    <= '0;
      r_acc     <= '0;
      r_prod_hi <= '0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_p       <= '0;
      r_l       <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_op   <= op_code;
            r_data <= op_data;
            if (op_code == OP_MUL) begin
              r_p     <= '0;
              r_l     <= op_data;
              r_cnt   <= '0;
              r_state <= S_MUL;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          if (w_ill) begin
            r_err <= 1'b1;
          end else begin
            r_acc <= w_res;
            r_c   <= w_c;
            r_v   <= w_v;
            r_z   <= (w_res == '0);
            r_n   <= w_res[N-1];
          end
        end
        S_MUL: begin
          r_p   <= w_p_nx;
          r_l   <= w_l_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b1;
            r_acc     <= w_l_nx;
            r_prod_hi <= w_p_nx;
            r_c       <= (w_p_nx != '0);
            r_v       <= (w_p_nx != '0);
            r_z       <= (w_l_nx == '0);
            r_n       <= w_l_nx[N-1];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_alu_sequencer.sv
// Self-checking bench: behavioural ALU attached to the DUT, directed plus random
// ops compared against an arithmetic model of the accumulator and flags.
module tb_acc_alu_sequencer;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [3:0]   op_code = '0;
  logic [N-1:0] op_data = '0;
  logic [N-1:0] acc, prod_hi;
  logic         flag_c, flag_v, flag_z, flag_n;
  logic         done, err;
  logic [N-1:0] alu_in0, alu_in1;
  logic [2:0]   alu_ctrl;
  logic         alu_c_in;
  logic [N-1:0] alu_result;
  logic         alu_c_out, alu_v;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_acc = '0, m_ph = '0;
  logic       m_c = 0, m_v = 0, m_z = 0, m_n = 0;

  always #5 clk = ~clk;

  acc_alu_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_data(op_data), .acc(acc), .prod_hi(prod_hi),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .done(done), .err(err), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_ctrl(alu_ctrl), .alu_c_in(alu_c_in), .alu_result(alu_result),
    .alu_c_out(alu_c_out), .alu_v(alu_v)
  );

  // Behavioural n-bit ALU: 000 add, 001 add of inverted in1, 010 or, 100 and, 110 not
  logic [7:0] alu_b;
  logic [8:0] alu_s;
  always_comb begin
    alu_b      = (alu_ctrl == 3'b001) ? ~alu_in1 : alu_in1;
    alu_s      = {1'b0, alu_in0} + {1'b0, alu_b} + {8'd0, alu_c_in};
    alu_result = '0;
    alu_c_out  = 1'b0;
    alu_v      = 1'b0;
    case (alu_ctrl)
      3'b000, 3'b001: begin
        alu_result = alu_s[7:0];
        alu_c_out  = alu_s[8];
        alu_v      = (alu_in0[7] == alu_b[7]) && (alu_s[7] != alu_in0[7]);
      end
      3'b010:  alu_result = alu_in0 | alu_in1;
      3'b100:  alu_result = alu_in0 & alu_in1;
      3'b110:  alu_result = ~alu_in0;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string pfx);
    chk({pfx, " acc"}, 16'(acc), 16'(m_acc));
    chk({pfx, " prod_hi"}, 16'(prod_hi), 16'(m_ph));
    chk({pfx, " C"}, 16'(flag_c), 16'(m_c));
    chk({pfx, " V"}, 16'(flag_v), 16'(m_v));
    chk({pfx, " Z"}, 16'(flag_z), 16'(m_z));
    chk({pfx, " N"}, 16'(flag_n), 16'(m_n));
  endtask

  task automatic model_apply(input logic [3:0] code, input logic [7:0] data, output logic ill);
    int u, s, sa, sd, ci, p;
    sa = $signed(m_acc);
    sd = $signed(data);
    ill = 1'b0;
    case (code)
      4'd0: m_acc = data;
      4'd1, 4'd2: begin
        ci = (code == 4'd2 && m_c) ? 1 : 0;
        u = int'(m_acc) + int'(data) + ci;
        s = sa + sd + ci;
        m_acc = u[7:0];
        m_c = (u > 255);
        m_v = (s > 127) || (s < -128);
      end
      4'd3: begin
        u = int'(m_acc) - int'(data);
        s = sa - sd;
        m_c = (m_acc >= data);
        m_v = (s > 127) || (s < -128);
        m_acc = u[7:0];
      end
      4'd4: begin m_acc = m_acc | data; m_c = 0; m_v = 0; end
      4'd5: begin m_acc = m_acc & data; m_c = 0; m_v = 0; end
      4'd6: begin m_acc = ~m_acc; m_c = 0; m_v = 0; end
      4'd7: begin
        p = int'(m_acc) * int'(data);
        m_acc = p[7:0];
        m_ph = p[15:8];
        m_c = (p[15:8] != 0);
        m_v = m_c;
      end
      4'd8: begin m_acc = '0; m_c = 0; m_v = 0; end
      default: ill = 1'b1;
    endcase
    if (!ill) begin
      m_z = (m_acc == 0);
      m_n = m_acc[7];
    end
  endtask

  // Issue one op; returns the ALU ctrl/c_in seen in the first cycle after accept.
  task automatic run_op(input logic [3:0] code, input logic [7:0] data, input bit hold,
                        output logic [2:0] ctrl_x, output logic cin_x);
    int edges, lowcyc, exp_lat;
    logic ill;
    string pfx;
    pfx = $sformatf("op%0h/%02h", code, data);
    @(negedge clk);
    op_valid = 1'b1; op_code = code; op_data = data;
    chk({pfx, " ready_pre"}, 16'(op_ready), 16'd1);
    @(posedge clk); #1;
    if (!hold) op_valid = 1'b0;
    ctrl_x = alu_ctrl;
    cin_x  = alu_c_in;
    edges = 1; lowcyc = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (op_ready !== 1'b1) lowcyc++;
      @(posedge clk); #1;
      edges++;
    end
    op_valid = 1'b0;
    model_apply(code, data, ill);
    exp_lat = (code == 4'd7) ? N + 1 : 2;
    chk({pfx, " latency"}, 16'(edges), 16'(exp_lat));
    chk({pfx, " ready_low"}, 16'(lowcyc), 16'(exp_lat - 1));
    chk({pfx, " ready_back"}, 16'(op_ready), 16'd1);
    chk({pfx, " err"}, 16'(err), 16'(ill));
    chk_state(pfx);
    @(posedge clk); #1;
    chk({pfx, " done_pulse"}, 16'(done), 16'd0);
    chk({pfx, " err_pulse"}, 16'(err), 16'd0);
    chk({pfx, " ready_idle"}, 16'(op_ready), 16'd1);
  endtask

  initial begin
    logic [2:0] cx;
    logic       ci;
    int         dcnt;

    // Reset state
    #12;
    chk("rst acc", 16'(acc), 16'd0);
    chk("rst prod_hi", 16'(prod_hi), 16'd0);
    chk("rst flags", 16'({flag_c, flag_v, flag_z, flag_n}), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst err", 16'(err), 16'd0);
    chk("rst ready", 16'(op_ready), 16'd1);
    @(negedge clk); rst_n = 1'b1;

    // Signed overflow
    run_op(4'd0, 8'h7F, 0, cx, ci);
    run_op(4'd1, 8'h01, 0, cx, ci);
    chk("ovf ctrl", 16'(cx), 16'b000);
    chk("ovf acc", 16'(acc), 16'h80);
    chk("ovf CVNZ", 16'({flag_c, flag_v, flag_n, flag_z}), 16'b0110);

    // Subtract to zero
    run_op(4'd0, 8'h05, 0, cx, ci);
    run_op(4'd3, 8'h05, 0, cx, ci);
    chk("sub ctrl", 16'(cx), 16'b001);
    chk("sub cin", 16'(ci), 16'd1);
    chk("sub acc/ZCV", 16'({acc, flag_z, flag_c, flag_v}), 16'({8'h00, 3'b110}));

    // Carry chain
    run_op(4'd0, 8'hFF, 0, cx, ci);
    run_op(4'd1, 8'h01, 0, cx, ci);
    chk("carry acc/CZ", 16'({acc, flag_c, flag_z}), 16'({8'h00, 2'b11}));
    run_op(4'd2, 8'h00, 0, cx, ci);
    chk("adc cin", 16'(ci), 16'd1);
    chk("adc acc/C", 16'({acc, flag_c}), 16'({8'h01, 1'b0}));

    // Multiply
    run_op(4'd0, 8'h0D, 0, cx, ci);
    run_op(4'd7, 8'h0B, 0, cx, ci);
    chk("mul1 acc", 16'(acc), 16'h8F);
    chk("mul1 hi/C/V/N", 16'({prod_hi, flag_c, flag_v, flag_n}), 16'({8'h00, 3'b001}));
    run_op(4'd0, 8'hFF, 0, cx, ci);
    run_op(4'd7, 8'hFF, 1, cx, ci);   // op_valid held through the MUL
    chk("mul2 acc/hi", 16'({prod_hi, acc}), 16'hFE01);
    chk("mul2 C/V", 16'({flag_c, flag_v}), 16'b11);

    // Illegal code
    run_op(4'd0, 8'h3C, 0, cx, ci);
    run_op(4'd15, 8'hA5, 0, cx, ci);
    chk("ill acc", 16'(acc), 16'h3C);

    // Random ops against the model
    for (int k = 0; k < 40; k++)
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 0, cx, ci);

    // Reset during cycle 4 of a MUL
    run_op(4'd0, 8'h12, 0, cx, ci);
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd7; op_data = 8'h34;
    @(posedge clk); #1; op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_acc = '0; m_ph = '0; m_c = 0; m_v = 0; m_z = 0; m_n = 0;
    chk_state("midrst");
    chk("midrst ready", 16'(op_ready), 16'd1);
    chk("midrst done", 16'(done), 16'd0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    chk("midrst no_done", 16'(dcnt), 16'd0);
    chk_state("postrst");
    run_op(4'd1, 8'h21, 0, cx, ci);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_alu_sequencer.md
Name: acc_alu_sequencer

Overview:
- Accumulator-side controller for the n-bit ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's operand, carry-in and 3-bit ctrl inputs.
- It captures the ALU's result, carry-out and overflow into an accumulator and a flag register.
- It also runs a multi-cycle shift-add multiply by issuing repeated ALU ADDs.
- Sits between the processor's instruction decode and the combinational ALU.

Parameters:
- N, 8, datapath width; must match the attached ALU's n.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  request present
- op_ready  out  1  high only in IDLE; transfer on op_valid&&op_ready at rising clk
- op_code  in  4  operation select, see Behaviour
- op_data  in  N  operand
- acc  out  N  accumulator (low product for MUL)
- prod_hi  out  N  high half of last MUL product
- flag_c, flag_v, flag_z, flag_n  out  1 each  carry, overflow, zero, negative
- done  out  1  one-cycle pulse when an accepted op completes
- err  out  1  one-cycle pulse with done for an illegal op_code
- alu_in0, alu_in1  out  N  ALU operands
- alu_ctrl  out  3  ALU ctrl lines
- alu_c_in  out  1  ALU carry-in
- alu_result  in  N  ALU output
- alu_c_out, alu_v  in  1 each  ALU carry-out and overflow

Behaviour:
- Reset (async, any state): state=IDLE; acc, prod_hi, all flags, done, err=0; op_ready=1. An op in flight is discarded with no done.
- States: IDLE, EXEC, MUL.
  - IDLE->EXEC on accept, for any code other than MUL.
  - IDLE->MUL on accept of MUL.
  - EXEC->IDLE after exactly 1 cycle.
  - MUL->IDLE after exactly N cycles.
- Accept registers op_code and op_data. op_valid is ignored whenever op_ready=0.
- Latency:
  - Non-MUL: results and done visible after the 2nd rising edge following the accept edge; op_ready is high again in the same cycle.
  - MUL: done after N+1 edges following the accept edge.
- ALU drive (combinational from registered state):
  - EXEC: alu_in0=acc, alu_in1=op_data.
  - IDLE: alu_in0=acc, alu_in1=0, ctrl=000, c_in=0.
- op_code map: code: name, ctrl/c_in, effect.
  - 0: LOAD, no ALU. acc=data; Z,N updated; C,V held.
  - 1: ADD, 000/0. acc=result; C=alu_c_out; V=alu_v.
  - 2: ADC, 000/flag_c. Same flags as ADD.
  - 3: SUB, 001/1. acc=acc-data; C=alu_c_out (1 = no borrow); V=alu_v.
  - 4: OR, 010/0. C=V=0.
  - 5: AND, 100/0. C=V=0.
  - 6: NOT, 110/0. acc=~acc; C=V=0.
  - 7: MUL. Multi-cycle, see below.
  - 8: CLR. acc=0; Z=1; N=C=V=0.
  - 9-15: illegal. Pass through EXEC; no state change; done=err=1.
- Z and N are always computed on the new acc value, for every op except illegal.
- MUL (unsigned; multiplicand M=acc at accept, multiplier=op_data):
  - On accept: P=0, L=op_data.
  - Each MUL cycle: alu_in0=P, alu_in1=M, ctrl=000, c_in=0.
  - If L[0]=1: {P,L} <= {alu_c_out, alu_result, L} >> 1.
  - If L[0]=0: {P,L} <= {1'b0, P, L} >> 1, ALU result ignored.
  - After N iterations: acc=L, prod_hi=P, C=V=(P!=0), Z=(L==0), N=L[N-1].
  - acc and prod_hi outputs hold their previous values until completion.
- done/err are registered pulses and are never high for two consecutive cycles.
- Back-to-back ops are therefore one accept every 2 cycles.

Test Plan:
- Reset then idle: rst_n low -> acc=0x00, prod_hi=0x00, all flags=0, done=0, op_ready=1; pulse rst_n low mid-operation -> same values immediately, asynchronously.
- Signed overflow: LOAD 0x7F, ADD 0x01 -> acc=0x80, V=1, C=0, N=1, Z=0; done exactly 2 edges after each accept; alu_ctrl=000 during EXEC.
- Subtract to zero: LOAD 0x05, SUB 0x05 -> acc=0x00, Z=1, C=1, V=0; alu_ctrl=001, alu_c_in=1 during EXEC.
- Carry chain: LOAD 0xFF, ADD 0x01 -> acc=0x00, C=1, Z=1; ADC 0x00 -> acc=0x01, C=0; alu_c_in=1 during the ADC EXEC cycle.
- Multiply:
  - LOAD 0x0D, MUL 0x0B -> acc=0x8F, prod_hi=0x00, C=V=0, N=1; op_ready=0 for 8 cycles; done 9 edges after accept.
  - LOAD 0xFF, MUL 0xFF -> acc=0x01, prod_hi=0xFE, C=V=1.
- Protocol and illegal codes:
  - op_valid held high during MUL -> no second accept until op_ready returns.
  - op_code 0xF with acc=0x3C -> done=err=1 for one cycle; acc=0x3C and flags unchanged.
  - rst_n asserted during cycle 4 of a MUL -> no done, acc=0.
